// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expander (with helper module aes_sbox)
// Purpose  : AES-128 key schedule generator. The cipher key is captured one
//            32-bit column per cycle. Words w4..w43 are then computed one per
//            cycle and held in a 44-word store. A combinational read port
//            serves round keys to the AddRoundKey datapath.
// Ports    : clock, reset       - clock, synchronous active-high reset
//            key_start          - pulse; key column 0 is present this cycle
//            key_col_in[31:0]   - key column, [31:24] = row-0 byte
//            rk_round[3:0]      - round-key select 0..10 (>10 reads zero)
//            rk_col[1:0]        - column within the round key
//            rk_word[31:0]      - w[4*rk_round + rk_col]
//            key_expand_done    - schedule complete (level)
//            key_busy           - high while loading or expanding
//            dbg_word_idx[5:0]  - index of the word being written
// Options  : KEYEXP_ZEROIZE_EN - reset clears the store, and rk_word reads
//            zero while key_expand_done is low.
// Revision : 1.0 - initial release
// ============================================================================

// Combinational AES forward S-box.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];
endmodule

module aes_key_expander #(
  parameter int NUM_ROUNDS = 10,
  parameter int WORD_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              key_start,
  input  logic [WORD_W-1:0] key_col_in,
  input  logic [3:0]        rk_round,
  input  logic [1:0]        rk_col,
  output logic [WORD_W-1:0] rk_word,
  output logic              key_expand_done,
  output logic              key_busy,
  output logic [5:0]        dbg_word_idx
);

  localparam int        NUM_WORDS = 4 * (NUM_ROUNDS + 1);
  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic              done_q, done_d;
  logic [3:0]        rnd_q, rnd_d;     // round counter driving Rcon
  logic [WORD_W-1:0] mem_q [NUM_WORDS];
  logic [WORD_W-1:0] mem_d [NUM_WORDS];

  logic              wr_en;
  logic [5:0]        wr_addr;
  logic [WORD_W-1:0] wr_data;

  // ---------------------------------------------------------------------------
  // Next-word datapath: w[i] = w[i-4] ^ temp
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] w_prev, w_back4, rot_word, sub_word, temp_word, next_word;
  logic [7:0]        rcon;

  assign w_prev   = mem_q[idx_q - 6'd1];
  assign w_back4  = mem_q[idx_q - 6'd4];
  assign rot_word = {w_prev[23:0], w_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_word[8*g +: 8]),
      .out_byte (sub_word[8*g +: 8])
    );
  end

  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign temp_word = (idx_q[1:0] == 2'b00) ? (sub_word ^ {rcon, 24'h0}) : w_prev;
  assign next_word = w_back4 ^ temp_word;

  // ---------------------------------------------------------------------------
  // Control FSM: next state and write strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = done_q;
    rnd_d   = rnd_q;
    wr_en   = 1'b0;
    wr_addr = idx_q;
    wr_data = key_col_in;

    if (key_start) begin
      // A new key always restarts from column 0, from any state.
      state_d = LOAD;
      idx_d   = 6'd1;
      done_d  = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 6'd0;
    end else begin
      case (state_q)
        LOAD: begin
          wr_en = 1'b1;
          if (idx_q == 6'd3) begin
            state_d = EXPAND;
            idx_d   = 6'd4;
            rnd_d   = 4'd1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        EXPAND: begin
          wr_en   = 1'b1;
          wr_data = next_word;
          // Advance Rcon once the first word of a round has consumed it.
          if (idx_q[1:0] == 2'b00) rnd_d = rnd_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      done_q  <= 1'b0;
      rnd_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rnd_q   <= rnd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Schedule storage
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

`ifdef KEYEXP_ZEROIZE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
`else
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Read port and status
  // ---------------------------------------------------------------------------
  logic [5:0]        rd_addr;
  logic [WORD_W-1:0] rd_word;

  assign rd_addr = {rk_round, 2'b00} + {4'b0000, rk_col};
  assign rd_word = (rk_round > 4'd10) ? '0 : mem_q[rd_addr];

`ifdef KEYEXP_ZEROIZE_EN
  assign rk_word = done_q ? rd_word : '0;
`else
  assign rk_word = rd_word;
`endif

  assign key_expand_done = done_q;
  assign key_busy        = (state_q == LOAD) || (state_q == EXPAND);
  // idx_q rests at 43 in DONE and at 0 after reset, matching the debug view.
  assign dbg_word_idx    = idx_q;

endmodule
`default_nettype wire
